// File: rtl/instruction_sequencer.sv
// MSP430 (non-extended) fetch/decode/sequence control. Drives the register-file
// control inputs from the latched instruction word and the current sequencer state.
module instruction_sequencer #(
    parameter int RESET_STATE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] MDB,
    input  logic [15:0] PC,
    input  logic [15:0] operand,
    input  logic        Zcurrent,
    input  logic        Vcurrent,
    input  logic        Ncurrent,
    input  logic        Ccurrent,
    output logic [1:0]  MO,
    output logic [3:0]  srcA,
    output logic [3:0]  dstA,
    output logic [1:0]  As,
    output logic        Ad,
    output logic        OneOp,
    output logic        BW,
    output logic        incSrc,
    output logic        incDst,
    output logic        indirect,
    output logic        RW,
    output logic [3:0]  resultA,
    output logic        SRW,
    output logic        BranchExecute,
    output logic [15:0] BranchAddress,
    output logic        memWrite,
    output logic [15:0] srcOffset,
    output logic [15:0] dstOffset,
    output logic [15:0] IR,
    output logic        illegal
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_DECODE   = 3'd2;
    localparam logic [2:0] S_SRC_OFS  = 3'd3;
    localparam logic [2:0] S_DST_OFS  = 3'd4;
    localparam logic [2:0] S_PUSH_DEC = 3'd5;
    localparam logic [2:0] S_EXEC     = 3'd6;

    localparam int CW = (RESET_STATE_CYCLES > 1) ? $clog2(RESET_STATE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RESET_STATE_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [15:0]   ir_q, ir_d;
    logic [15:0]   src_ofs_q, src_ofs_d;
    logic [15:0]   dst_ofs_q, dst_ofs_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Instruction classification, all from the latched IR.
    logic       is_jump, is_fmt1, is_fmt2, fmt2_ok, is_illegal;
    logic       is_push, is_call, need_src, need_dst, dst_mem;
    logic       no_wb, srw_op, jump_taken;
    logic [3:0] op1, src_reg;
    logic [2:0] op2;
    logic [1:0] as_f;
    logic [15:0] jump_tgt;
    logic [2:0] after_src, after_dst;

    always_comb begin
        op1      = ir_q[15:12];
        op2      = ir_q[9:7];
        as_f     = ir_q[5:4];
        is_jump  = (ir_q[15:13] == 3'b001);
        is_fmt1  = (op1 >= 4'h4);
        is_fmt2  = (ir_q[15:10] == 6'b000100);
        fmt2_ok  = is_fmt2 && (op2 != 3'd6) && (op2 != 3'd7);
        // Anything that is not a jump, a format-I op or a supported format-II op traps.
        is_illegal = !(is_jump || is_fmt1 || fmt2_ok);
        is_push  = fmt2_ok && (op2 == 3'd4);
        is_call  = fmt2_ok && (op2 == 3'd5);
        src_reg  = is_fmt2 ? ir_q[3:0] : ir_q[11:8];
        need_src = (is_fmt1 || fmt2_ok) &&
                   (((as_f == 2'b01) && (src_reg != 4'd3)) ||
                    ((as_f == 2'b11) && (src_reg == 4'd0)));
        need_dst = is_fmt1 && ir_q[7];
        // A format-II operand is read-modify-write, so its destination follows As.
        dst_mem  = is_fmt1 ? ir_q[7] : (as_f != 2'b00);
        no_wb    = is_fmt1 && ((op1 == 4'h9) || (op1 == 4'hB));
        srw_op   = (is_fmt1 && (op1 != 4'h4) && (op1 != 4'hC) && (op1 != 4'hD)) ||
                   (fmt2_ok && ((op2 == 3'd0) || (op2 == 3'd2) || (op2 == 3'd3)));
        case (ir_q[12:10])
            3'b000:  jump_taken = !Zcurrent;
            3'b001:  jump_taken = Zcurrent;
            3'b010:  jump_taken = !Ccurrent;
            3'b011:  jump_taken = Ccurrent;
            3'b100:  jump_taken = Ncurrent;
            3'b101:  jump_taken = !(Ncurrent ^ Vcurrent);
            3'b110:  jump_taken = Ncurrent ^ Vcurrent;
            default: jump_taken = 1'b1;
        endcase
        jump_tgt  = PC + {{5{ir_q[9]}}, ir_q[9:0], 1'b0};
        after_dst = (is_push || is_call) ? S_PUSH_DEC : S_EXEC;
        after_src = need_dst ? S_DST_OFS : after_dst;
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        src_ofs_d = src_ofs_q;
        dst_ofs_d = dst_ofs_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cnt_q == CNT_LAST) state_d = S_FETCH;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_FETCH: begin
                ir_d    = MDB;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_jump || is_illegal) state_d = S_FETCH;
                else if (need_src)         state_d = S_SRC_OFS;
                else                       state_d = after_src;
            end
            S_SRC_OFS: begin
                src_ofs_d = MDB;
                state_d   = after_src;
            end
            S_DST_OFS: begin
                dst_ofs_d = MDB;
                state_d   = after_dst;
            end
            S_PUSH_DEC: state_d = S_EXEC;
            S_EXEC:     state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            src_ofs_q <= '0;
            dst_ofs_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            src_ofs_q <= src_ofs_d;
            dst_ofs_q <= dst_ofs_d;
            cnt_q     <= cnt_d;
        end
    end

    assign IR        = ir_q;
    assign srcOffset = src_ofs_q;
    assign dstOffset = dst_ofs_q;
    // Non-extended destination modes are register or indexed only, so never auto-incremented.
    assign incDst    = 1'b0;

    always_comb begin
        MO            = 2'd0;
        srcA          = '0;
        dstA          = '0;
        As            = '0;
        Ad            = 1'b0;
        OneOp         = 1'b0;
        BW            = 1'b0;
        incSrc        = 1'b0;
        indirect      = 1'b0;
        RW            = 1'b0;
        resultA       = '0;
        SRW           = 1'b0;
        BranchExecute = 1'b0;
        BranchAddress = '0;
        memWrite      = 1'b0;
        illegal       = 1'b0;
        if (is_fmt1 || is_fmt2) begin
            srcA  = src_reg;
            dstA  = ir_q[3:0];
            As    = as_f;
            Ad    = is_fmt1 && ir_q[7];
            OneOp = is_fmt2;
            BW    = ir_q[6];
        end
        case (state_q)
            S_FETCH: MO = 2'd1;
            S_DECODE: begin
                illegal = is_illegal;
                if (is_jump && jump_taken) begin
                    BranchExecute = 1'b1;
                    BranchAddress = jump_tgt;
                end
            end
            S_SRC_OFS, S_DST_OFS: MO = 2'd2;
            S_PUSH_DEC: MO = 2'd3;
            S_EXEC: begin
                indirect = as_f[1];
                // R2/R3 in autoincrement mode are constant generators, R0 is an immediate.
                incSrc   = (as_f == 2'b11) && (src_reg != 4'd0) &&
                           (src_reg != 4'd2) && (src_reg != 4'd3);
                RW       = !dst_mem && !no_wb && !is_push && !is_call;
                resultA  = RW ? ir_q[3:0] : 4'd0;
                SRW      = srw_op;
                memWrite = (dst_mem && !no_wb) || is_push || is_call;
                if (is_call) begin
                    BranchExecute = 1'b1;
                    BranchAddress = operand;
                end
            end
            default: ;
        endcase
    end

endmodule
